// File: rtl/mem_byte_responder.sv
// mem_byte_responder: byte-serial memory target with programmable wait states over an internal byte RAM
//   clk, nrst (async, active-low)
//   enable, wr, dbl_byte_en, address[15:0], data_in[7:0], wait_cycles[3:0] : request from the controller
//   data_out[7:0] : last read byte, held until the next read completes
//   cmp, ack : per-byte and end-of-transaction one-cycle pulses
//   busy : not idle
//   err : only with MEM_BYTE_RESP_ERR_EN; pulses with cmp on out-of-range bytes (errored reads return 8'hFF)
module mem_byte_responder #(
  parameter int          DEPTH    = 256,
  parameter logic [15:0] RAM_BASE = 16'h8000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic        wr,
  input  logic        dbl_byte_en,
  input  logic [15:0] address,
  input  logic [7:0]  data_in,
  input  logic [3:0]  wait_cycles,
  output logic [7:0]  data_out,
  output logic        cmp,
  output logic        ack,
  output logic        busy
`ifdef MEM_BYTE_RESP_ERR_EN
  , output logic      err
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACCESS, GAP, HOLD} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, w;
  logic second, second_n, dbl, wr_l, lat, relat, commit, ack_n, in_range;
  logic [15:0] addr_l;
  logic [7:0] din_l, rd_byte;
  logic [AW-1:0] idx;
  logic [7:0] mem [DEPTH];
  // 17-bit compare so a window ending at 16'hFFFF cannot wrap
  assign in_range = {1'b0, addr_l} >= {1'b0, RAM_BASE} && {1'b0, addr_l} < {1'b0, RAM_BASE} + 17'(DEPTH);
  assign idx = AW'(addr_l - RAM_BASE);
  assign busy = state != IDLE;
`ifdef MEM_BYTE_RESP_ERR_EN
  assign rd_byte = in_range ? mem[idx] : 8'hFF;
`else
  assign rd_byte = in_range ? mem[idx] : (addr_l < 16'h8000 ? 8'h00 : 8'hFF);
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    second_n = second;
    lat = 1'b0;
    relat = 1'b0;
    commit = 1'b0;
    ack_n = 1'b0;
    case (state)
      IDLE: if (enable) begin
        lat = 1'b1;
        cnt_n = 4'd0;
        second_n = 1'b0;
        state_n = ACCESS;
      end
      ACCESS: if (!enable) state_n = IDLE;
        else if (cnt != w) cnt_n = cnt + 4'd1;
        else begin
          commit = 1'b1;
          if (dbl && !second) begin
            second_n = 1'b1;
            state_n = GAP;
          end else begin
            ack_n = 1'b1;
            state_n = HOLD;
          end
        end
      GAP: if (!enable) state_n = IDLE;
        else begin
          relat = 1'b1;
          cnt_n = 4'd0;
          state_n = ACCESS;
        end
      default: if (!enable) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      cnt <= 4'd0;
      second <= 1'b0;
      w <= 4'd0;
      dbl <= 1'b0;
      wr_l <= 1'b0;
      addr_l <= 16'd0;
      din_l <= 8'd0;
      data_out <= 8'h00;
      cmp <= 1'b0;
      ack <= 1'b0;
`ifdef MEM_BYTE_RESP_ERR_EN
      err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      second <= second_n;
      cmp <= commit;
      ack <= ack_n;
`ifdef MEM_BYTE_RESP_ERR_EN
      err <= commit & ~in_range;
`endif
      if (lat) begin
        w <= wait_cycles;
        dbl <= dbl_byte_en;
      end
      if (lat || relat) begin
        wr_l <= wr;
        addr_l <= address;
        din_l <= data_in;
      end
      if (commit && !wr_l) data_out <= rd_byte;
    end
  end
  // RAM has no reset so its contents survive nrst
  always_ff @(posedge clk) if (commit && wr_l && in_range) mem[idx] <= din_l;
endmodule

// File: tb/tb_mem_byte_responder.sv
// tb_mem_byte_responder: directed scoreboard bench for mem_byte_responder
module tb_mem_byte_responder;
  logic clk = 1'b0, nrst, enable, wr, dbl_byte_en, cmp, ack, busy;
  logic [15:0] address;
  logic [7:0] data_in, data_out;
  logic [3:0] wait_cycles;
`ifdef MEM_BYTE_RESP_ERR_EN
  logic err;
`endif
  int n_chk = 0, n_err = 0;
  logic [7:0] model [logic [15:0]];
  logic [7:0] exp_q [$];
  always #5 clk = ~clk;
  mem_byte_responder dut (
    .clk(clk), .nrst(nrst), .enable(enable), .wr(wr), .dbl_byte_en(dbl_byte_en),
    .address(address), .data_in(data_in), .wait_cycles(wait_cycles),
    .data_out(data_out), .cmp(cmp), .ack(ack), .busy(busy)
`ifdef MEM_BYTE_RESP_ERR_EN
    , .err(err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bit in_rng(input logic [15:0] a);
    return a >= 16'h8000 && a < 16'h8100;
  endfunction
  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    if (in_rng(a)) return model[a];
`ifdef MEM_BYTE_RESP_ERR_EN
    return 8'hFF;
`else
    return a < 16'h8000 ? 8'h00 : 8'hFF;
`endif
  endfunction
  task automatic push(input bit w_r, input logic [15:0] a, input logic [7:0] d);
    if (w_r) begin
      if (in_rng(a)) model[a] = d;
    end else exp_q.push_back(exp_rd(a));
  endtask
  task automatic check_byte(input bit w_r, input logic [15:0] a);
    if (!w_r) chk("rdata", data_out, exp_q.pop_front());
`ifdef MEM_BYTE_RESP_ERR_EN
    chk("err", err, !in_rng(a));
`else
    if (a == 16'hFFFF) chk("addr_tag", a, 16'hFFFF);
`endif
  endtask
  task automatic txn(input bit w_r, input bit dbl, input logic [15:0] a0, input logic [7:0] d0,
                     input logic [15:0] a1, input logic [7:0] d1, input int wc, input int hold);
    int cyc, acks;
    @(negedge clk);
    enable = 1'b1; wr = w_r; dbl_byte_en = dbl; wait_cycles = 4'(wc); address = a0; data_in = d0;
    push(w_r, a0, d0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!cmp && cyc < 40);
    chk("lat_first", cyc, wc + 2);
    check_byte(w_r, a0);
    chk("ack_first", ack, !dbl);
    if (dbl) begin
      address = a1; data_in = d1;
      push(w_r, a1, d1);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!cmp && cyc < 40);
      chk("lat_second", cyc, wc + 2);
      check_byte(w_r, a1);
      chk("ack_second", ack, 1);
    end
    acks = 0;
    repeat (hold) begin
      @(negedge clk);
      acks += int'(ack);
      chk("busy_hold", busy, 1);
    end
    if (hold > 0) chk("single_ack", acks, 0);
    enable = 1'b0;
    @(negedge clk);
    chk("busy_clear", busy, 0);
    chk("ack_low", ack, 0);
  endtask
  initial begin
    int seen;
    nrst = 1'b0; enable = 1'b0; wr = 1'b0; dbl_byte_en = 1'b0;
    address = 16'h0; data_in = 8'h0; wait_cycles = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_cmp", cmp, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    nrst = 1'b1;
    txn(1, 0, 16'h8010, 8'hA5, 0, 0, 0, 0);
    txn(0, 0, 16'h8010, 0, 0, 0, 0, 0);
    txn(1, 1, 16'h8020, 8'hEF, 16'h8021, 8'hBE, 3, 0);
    txn(0, 1, 16'h8020, 0, 16'h8021, 0, 1, 0);
    txn(0, 0, 16'h8021, 0, 0, 0, 2, 0);
    txn(1, 0, 16'h1234, 8'h11, 0, 0, 2, 0);
    txn(0, 0, 16'h1234, 0, 0, 0, 2, 0);
    txn(0, 0, 16'h8100, 0, 0, 0, 0, 0);
    txn(1, 0, 16'h80FF, 8'h5A, 0, 0, 1, 0);
    txn(0, 0, 16'h80FF, 0, 0, 0, 0, 0);
    txn(0, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    txn(0, 0, 16'h8010, 0, 0, 0, 0, 5);
    @(negedge clk);
    enable = 1'b1; wr = 1'b1; dbl_byte_en = 1'b0; wait_cycles = 4'd7; address = 16'h8010; data_in = 8'h3C;
    seen = 0;
    repeat (3) begin @(negedge clk); seen += int'(cmp | ack); end
    enable = 1'b0;
    repeat (2) begin @(negedge clk); seen += int'(cmp | ack); end
    chk("abort_no_cmp", seen, 0);
    chk("abort_idle", busy, 0);
    txn(0, 0, 16'h8010, 0, 0, 0, 0, 0);
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; wait_cycles = 4'd7; address = 16'h8021;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data_out", data_out, 8'h00);
    chk("mid_rst_cmp", cmp, 0);
    chk("mid_rst_ack", ack, 0);
    enable = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    txn(0, 0, 16'h8021, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
